ad9970_reg_cfg: RTL and testbench

AD9970_REG_CFG -- requirements
Module: ad9970_reg_cfg

---
 rtl/ad9970_reg_cfg_pkg.sv | 45 ++++
 rtl/ad9970_reg_cfg_if.sv | 26 ++
 rtl/ad9970_reg_cfg_spi_shifter.sv | 72 +++++++
 rtl/ad9970_reg_cfg.sv | 101 ++++++++++
 tb/tb_ad9970_reg_cfg.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ad9970_reg_cfg_pkg.sv
// Shared constants, FSM encoding and frame assembly for the AD9970 register
// configuration sequencer.
package ad9970_cfg_pkg;

  localparam int FRAME_BITS = 32;
  localparam int NUM_FRAMES = 6;

  localparam logic [7:0] ADDR_SYNC_LOC  = 8'h10;
  localparam logic [7:0] ADDR_SYNC_WORD = 8'h11;
  localparam logic [7:0] ADDR_SYNC_CTRL = 8'h12;
  localparam logic [7:0] ADDR_HBLK_TOG1 = 8'h13;
  localparam logic [7:0] ADDR_HBLK_TOG2 = 8'h14;
  localparam logic [7:0] ADDR_UPDATE    = 8'h00;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef struct packed {
    logic [12:0] sync_loc;
    logic [15:0] sync_word;
    logic        align_right;
    logic [12:0] tog1;
    logic [12:0] tog2;
  } cfg_t;

  // Frame idx of the fixed six-register sequence: {addr, zero-extended data}.
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [2:0] idx,
                                                       input cfg_t c);
    logic [7:0]  addr;
    logic [23:0] data;
    case (idx)
      3'd0:    begin addr = ADDR_SYNC_LOC;  data = {11'b0, c.sync_loc};    end
      3'd1:    begin addr = ADDR_SYNC_WORD; data = {8'b0, c.sync_word};    end
      3'd2:    begin addr = ADDR_SYNC_CTRL; data = {23'b0, c.align_right}; end
      3'd3:    begin addr = ADDR_HBLK_TOG1; data = {11'b0, c.tog1};        end
      3'd4:    begin addr = ADDR_HBLK_TOG2; data = {11'b0, c.tog2};        end
      default: begin addr = ADDR_UPDATE;    data = 24'h000001;             end
    endcase
    return {addr, data};
  endfunction

endpackage

// File: rtl/ad9970_reg_cfg_if.sv
// Control and serial-port bundle between the host logic and the sequencer.
interface ad9970_reg_cfg_if;
  logic        i_start;
  logic [12:0] iv_sync_start_loc;
  logic [15:0] iv_sync_word;
  logic        i_align_right;
  logic [12:0] iv_hblk_tog1;
  logic [12:0] iv_hblk_tog2;
  logic        o_sck;
  logic        o_sdata;
  logic        o_sl;
  logic        o_busy;
  logic        o_done;

  modport master (
    output i_start, iv_sync_start_loc, iv_sync_word, i_align_right,
           iv_hblk_tog1, iv_hblk_tog2,
    input  o_sck, o_sdata, o_sl, o_busy, o_done
  );

  modport slave (
    input  i_start, iv_sync_start_loc, iv_sync_word, i_align_right,
           iv_hblk_tog1, iv_hblk_tog2,
    output o_sck, o_sdata, o_sl, o_busy, o_done
  );
endinterface

// File: rtl/ad9970_reg_cfg_spi_shifter.sv
// SCK divider, 32-bit MSB-first shift register and bit counter for one frame.
// load_i primes the word; run_i lets SCK toggle every CLK_DIV cycles.
module ad9970_spi_shifter
  import ad9970_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  run_i,
  input  logic [FRAME_BITS-1:0] data_i,
  output logic                  sck_o,
  output logic                  sdata_o,
  output logic                  frame_done_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]            div_q, div_d;
  logic                  sck_q, sck_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [5:0]            bit_q, bit_d;
  logic                  tick;

  assign tick = run_i && (div_q == DIV_LAST);
  // The last falling edge coincides with the parent leaving SHIFT.
  assign frame_done_o = tick && sck_q && (bit_q == 6'(FRAME_BITS - 1));

  always_comb begin
    div_d = div_q;
    sck_d = sck_q;
    sh_d  = sh_q;
    bit_d = bit_q;
    if (load_i) begin
      div_d = '0;
      sck_d = 1'b0;
      sh_d  = data_i;
      bit_d = '0;
    end else if (run_i) begin
      if (tick) begin
        div_d = '0;
        sck_d = ~sck_q;
        // Data advances only on falling SCK so it is centred on each rise.
        if (sck_q) begin
          sh_d  = {sh_q[FRAME_BITS-2:0], 1'b0};
          bit_d = bit_q + 6'd1;
        end
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      sck_q <= 1'b0;
      sh_q  <= '0;
      bit_q <= '0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
      sh_q  <= sh_d;
      bit_q <= bit_d;
    end
  end

  assign sck_o   = sck_q;
  assign sdata_o = sh_q[FRAME_BITS-1];

endmodule

// File: rtl/ad9970_reg_cfg.sv
// AD9970 register configuration sequencer: captures the timing fields on start
// and writes six SPI frames (LOAD, SHIFT, GAP each) followed by a done pulse.
module ad9970_reg_cfg
  import ad9970_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int SL_GAP  = 2
) (
  input  logic               clk,
  input  logic               reset,
  ad9970_reg_cfg_if.slave    bus
);

  localparam logic [7:0] GAP_LAST = 8'(SL_GAP - 1);

  logic [2:0]            state_q, state_d;
  logic [2:0]            frm_q, frm_d;
  logic [7:0]            gap_q, gap_d;
  cfg_t                  cfg_q, cfg_d, cfg_in;
  logic                  sh_load, sh_run, sh_done, sh_sck, sh_sdata;
  logic                  in_frame;
  logic [FRAME_BITS-1:0] ld_word;

  assign cfg_in = {bus.iv_sync_start_loc, bus.iv_sync_word, bus.i_align_right,
                   bus.iv_hblk_tog1, bus.iv_hblk_tog2};

  // The first frame loads on the accepting edge, before cfg_q holds the inputs.
  assign ld_word = (state_q == S_IDLE) ? frame_word(3'd0, cfg_in)
                                       : frame_word(frm_q, cfg_q);

  always_comb begin
    state_d = state_q;
    frm_d   = frm_q;
    gap_d   = gap_q;
    cfg_d   = cfg_q;
    sh_load = 1'b0;
    case (state_q)
      S_IDLE: if (bus.i_start) begin
        state_d = S_LOAD;
        cfg_d   = cfg_in;
        frm_d   = '0;
        sh_load = 1'b1;
      end
      S_LOAD: state_d = S_SHIFT;
      S_SHIFT: if (sh_done) begin
        state_d = S_GAP;
        frm_d   = frm_q + 3'd1;
        gap_d   = '0;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (frm_q == 3'(NUM_FRAMES)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            sh_load = 1'b1;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      frm_q   <= '0;
      gap_q   <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      frm_q   <= frm_d;
      gap_q   <= gap_d;
      cfg_q   <= cfg_d;
    end
  end

  assign sh_run = (state_q == S_SHIFT);

  ad9970_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk          (clk),
    .reset        (reset),
    .load_i       (sh_load),
    .run_i        (sh_run),
    .data_i       (ld_word),
    .sck_o        (sh_sck),
    .sdata_o      (sh_sdata),
    .frame_done_o (sh_done)
  );

  assign in_frame    = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign bus.o_sl    = ~in_frame;
  assign bus.o_sck   = sh_sck;
  assign bus.o_sdata = in_frame & sh_sdata;
  assign bus.o_busy  = in_frame || (state_q == S_GAP);
  assign bus.o_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_ad9970_reg_cfg.sv
// Bench: two sequencers (default timing and CLK_DIV=2/SL_GAP=1) with an SPI
// slave model that decodes frames and checks SCK/SDATA/SL timing.
module tb_ad9970_reg_cfg;
  localparam int DA = 4, GA = 2, DB = 2, GB = 1;
  localparam int LAT_A = 6 * (1 + 64 * DA + GA) + 1;
  localparam int LAT_B = 6 * (1 + 64 * DB + GB) + 1;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;
  int   cyc = 0;
  int   checks = 0, failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ad9970_reg_cfg_if ifa ();
  ad9970_reg_cfg_if ifb ();

  ad9970_reg_cfg #(.CLK_DIV(DA), .SL_GAP(GA)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
  ad9970_reg_cfg #(.CLK_DIV(DB), .SL_GAP(GB)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  // SPI slave model state, one slot per DUT
  int          dv [2] = '{DA, DB};
  logic        psck [2], psd [2], psl [2];
  logic        prst [2] = '{1'b1, 1'b1};
  logic [31:0] acc [2];
  int          nbits [2], stable [2], last_rise [2], ndone [2], done_cyc [2];
  int          v_setup [2], v_hold [2], v_per [2], v_slsck [2], v_slsd [2];
  int          v_part [2], v_busy [2];
  logic [31:0] frq0 [$];
  logic [31:0] frq1 [$];
  logic [31:0] expf [2][6];
  int          t0 [2];

  task automatic mon(input int k, input logic rst, input logic sck, input logic sd,
                     input logic sl, input logic done, input logic busy);
    if (rst || prst[k]) begin
      acc[k] = '0; nbits[k] = 0; stable[k] = 0; last_rise[k] = -1000;
    end else begin
      if (sl && sck) v_slsck[k]++;
      if (sl && sd)  v_slsd[k]++;
      if (sd !== psd[k]) begin
        if (cyc - last_rise[k] < dv[k]) v_hold[k]++;
        stable[k] = 0;
      end else stable[k]++;
      if (!sl && psl[k]) nbits[k] = 0;
      if (sck && !psck[k]) begin
        acc[k] = {acc[k][30:0], sd};
        nbits[k]++;
        if (stable[k] < dv[k]) v_setup[k]++;
        if (nbits[k] > 1 && cyc - last_rise[k] != 2 * dv[k]) v_per[k]++;
        last_rise[k] = cyc;
      end
      if (sl && !psl[k]) begin
        if (nbits[k] == 32) begin
          if (k == 0) frq0.push_back(acc[k]); else frq1.push_back(acc[k]);
        end else v_part[k]++;
        nbits[k] = 0;
      end
      if (done) begin
        ndone[k]++; done_cyc[k] = cyc;
        if (busy) v_busy[k]++;
      end
    end
    psck[k] = sck; psd[k] = sd; psl[k] = sl; prst[k] = rst;
  endtask

  always @(negedge clk) begin
    mon(0, rst_a, ifa.o_sck, ifa.o_sdata, ifa.o_sl, ifa.o_done, ifa.o_busy);
    mon(1, rst_b, ifb.o_sck, ifb.o_sdata, ifb.o_sl, ifb.o_done, ifb.o_busy);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] outs(input int k);
    if (k == 0) return {ifa.o_sck, ifa.o_sdata, ifa.o_sl, ifa.o_busy, ifa.o_done};
    return {ifb.o_sck, ifb.o_sdata, ifb.o_sl, ifb.o_busy, ifb.o_done};
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? frq0.size() : frq1.size();
  endfunction

  function automatic logic [31:0] qget(input int k, input int i);
    if (i >= qsize(k)) return 32'hFFFF_FFFF;
    return (k == 0) ? frq0[i] : frq1[i];
  endfunction

  task automatic set_pins(input int k, input logic [12:0] loc, input logic [15:0] w,
                          input logic al, input logic [12:0] t1, input logic [12:0] t2);
    if (k == 0) begin
      ifa.iv_sync_start_loc = loc; ifa.iv_sync_word = w; ifa.i_align_right = al;
      ifa.iv_hblk_tog1 = t1; ifa.iv_hblk_tog2 = t2;
    end else begin
      ifb.iv_sync_start_loc = loc; ifb.iv_sync_word = w; ifb.i_align_right = al;
      ifb.iv_hblk_tog1 = t1; ifb.iv_hblk_tog2 = t2;
    end
  endtask

  // Pins plus the frame list a slave must decode: address * 2^24 + value.
  task automatic drive(input int k, input logic [12:0] loc, input logic [15:0] w,
                       input logic al, input logic [12:0] t1, input logic [12:0] t2);
    set_pins(k, loc, w, al, t1, t2);
    expf[k][0] = 32'h1000_0000 + 32'(loc);
    expf[k][1] = 32'h1100_0000 + 32'(w);
    expf[k][2] = 32'h1200_0000 + 32'(al);
    expf[k][3] = 32'h1300_0000 + 32'(t1);
    expf[k][4] = 32'h1400_0000 + 32'(t2);
    expf[k][5] = 32'h0000_0001;
  endtask

  task automatic drive_rand(input int k);
    drive(k, 13'($urandom), 16'($urandom), 1'($urandom), 13'($urandom), 13'($urandom));
  endtask

  task automatic set_start(input int k, input logic v);
    if (k == 0) ifa.i_start = v; else ifb.i_start = v;
  endtask

  task automatic start(input int k);
    if (k == 0) frq0.delete(); else frq1.delete();
    @(posedge clk); #1;
    set_start(k, 1'b1);
    t0[k] = cyc;
    @(posedge clk); #1;
    set_start(k, 1'b0);
  endtask

  task automatic finish_check(input int k, input string nm, input int n0);
    int lat;
    lat = (k == 0) ? LAT_A : LAT_B;
    for (int i = 0; i < lat + 50 && ndone[k] == n0; i++) @(posedge clk);
    chk($sformatf("%s_latency", nm), done_cyc[k] - t0[k], lat);
    repeat (40) @(posedge clk);
    chk($sformatf("%s_ndone", nm), ndone[k] - n0, 1);
    chk($sformatf("%s_nframes", nm), qsize(k), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s_frame%0d", nm, i), qget(k, i), expf[k][i]);
    @(negedge clk);
    chk($sformatf("%s_idle_outs", nm), outs(k), 5'b00100);
  endtask

  task automatic run_check(input int k, input string nm);
    int n0;
    n0 = ndone[k];
    start(k);
    @(negedge clk);
    chk($sformatf("%s_busy", nm), outs(k), 5'b00010 | (outs(k) & 5'b01000));
    finish_check(k, nm, n0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    ifa.i_start = 1'b0; ifb.i_start = 1'b0;
    set_pins(0, '0, '0, 1'b0, '0, '0);
    set_pins(1, '0, '0, 1'b0, '0, '0);
    repeat (4) @(posedge clk);
    #1 rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("reset_outs_A", outs(0), 5'b00100);
    chk("reset_outs_B", outs(1), 5'b00100);

    // Directed sequence with the reference register values
    drive(0, 13'd124, 16'h8421, 1'b1, 13'd0, 13'd137);
    run_check(0, "dir");

    // Retrigger while busy and input changes after capture
    drive_rand(0);
    n0 = ndone[0];
    start(0);
    repeat (9) @(posedge clk);
    #1 set_pins(0, '1, '1, 1'b1, '1, '1);
    repeat (89) @(posedge clk);
    #1 set_start(0, 1'b1);
    @(posedge clk); #1 set_start(0, 1'b0);
    finish_check(0, "retrig", n0);

    // Abort in the middle of the third frame, with a start coinciding with reset
    drive_rand(0);
    start(0);
    begin
      int i;
      for (i = 0; i < LAT_A && !(frq0.size() == 2 && nbits[0] >= 16); i++) @(posedge clk);
      chk("abort_reached", 32'(i < LAT_A), 32'd1);
    end
    n0 = ndone[0];
    #1 rst_a = 1'b1; set_start(0, 1'b1);
    @(posedge clk); #1 rst_a = 1'b0; set_start(0, 1'b0);
    @(negedge clk);
    chk("abort_outs", outs(0), 5'b00100);
    repeat (100) @(posedge clk);
    chk("abort_no_done", ndone[0] - n0, 0);
    @(negedge clk);
    chk("abort_start_ignored", outs(0), 5'b00100);
    drive_rand(0);
    run_check(0, "after_abort");

    // Fast timing: all-ones boundary values then random values
    drive(1, '1, '1, 1'b1, '1, '1);
    run_check(1, "fast_ones");
    drive_rand(1);
    run_check(1, "fast_rand");

    for (int k = 0; k < 2; k++) begin
      chk($sformatf("setup_viol_%0d", k), v_setup[k], 0);
      chk($sformatf("hold_viol_%0d", k), v_hold[k], 0);
      chk($sformatf("sck_period_viol_%0d", k), v_per[k], 0);
      chk($sformatf("sck_while_sl_%0d", k), v_slsck[k], 0);
      chk($sformatf("sdata_while_sl_%0d", k), v_slsd[k], 0);
      chk($sformatf("partial_frame_%0d", k), v_part[k], 0);
      chk($sformatf("busy_at_done_%0d", k), v_busy[k], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
